axi_stream_insert_header_pipe: RTL and testbench
================================================

AXI_STREAM_INSERT_HEADER_PIPE -- requirements
Module: axi_stream_insert_header_pipe

Interface
REQ-001 Parameter DATA_WD, default 32: data bus width in bits, a multiple of 8.
REQ-002 Parameter DATA_BYTE_WD, default 4 (DATA_WD/8): bytes per beat.
REQ-003 Parameter BYTE_CNT_WD, default 2 (clog2(DATA_BYTE_WD)): width of the header byte count.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 valid_in / ready_in  in / out  1 / 1  payload stream handshake.
REQ-007 data_in  in  DATA_WD  payload beat; byte 0 is bits [DATA_WD-1 -: 8], i.e. MSB-first.
REQ-008 keep_in  in  DATA_BYTE_WD  byte valids, MSB-aligned and contiguous (e.g. 1111, 1110, 1100, 1000).
REQ-009 last_in  in  1  marks the final payload beat.
REQ-010 valid_out / ready_out  out / in  1 / 1  output stream handshake.
REQ-011 data_out, keep_out, last_out  out  DATA_WD, DATA_BYTE_WD, 1  output beat, using the same MSB-first and MSB-aligned keep convention.
REQ-012 valid_insert / ready_insert  in / out  1 / 1  header handshake, one header per packet.
REQ-013 data_insert  in  DATA_WD  header word; the valid header bytes are its low N bytes.
REQ-014 keep_insert  in  DATA_BYTE_WD  header byte valids; informational only and not used for alignment.
REQ-015 byte_insert_cnt  in  BYTE_CNT_WD  header byte count N, sampled with the header handshake; value 0 means N = DATA_BYTE_WD.

Function
REQ-016 The module SHALL emit each packet as its N header bytes followed immediately by all valid payload bytes, packed MSB-first with no gaps.
REQ-017 FSM states:
- IDLE: ready_insert=1, ready_in=0; a header handshake latches data_insert and N and moves to STREAM.
- STREAM: ready_insert=0.
- FLUSH: ready_in=0, ready_insert=0.
REQ-018 The output SHALL be a single register stage; "slot free" SHALL mean (!valid_out || ready_out).
REQ-019 In STREAM, ready_in SHALL equal slot free; payload SHALL never be accepted before its header.
REQ-020 Each payload handshake SHALL load one output beat on the same edge, so valid_out rises one cycle after the first payload handshake.
REQ-021 Output beat composition:
- first beat: {N header bytes, first DATA_BYTE_WD-N bytes of the current payload beat};
- later beats: {last N bytes of the previous payload beat, first DATA_BYTE_WD-N bytes of the current beat}.
REQ-022 Non-last payload beats SHALL be treated as fully valid regardless of keep_in.
REQ-023 On the last payload beat with K valid bytes:
- if N+K <= DATA_BYTE_WD, the output beat SHALL carry last_out=1 and keep_out equal to the top N+K bits set, and the FSM SHALL return to IDLE;
- otherwise the beat SHALL be full with last_out=0, the FSM SHALL enter FLUSH, and one more beat SHALL carry N+K-DATA_BYTE_WD bytes with last_out=1, loaded when the slot is free, then the FSM SHALL return to IDLE.
REQ-024 When N = DATA_BYTE_WD, the first output beat SHALL be the whole header with keep all ones, and the payload SHALL follow delayed by one beat with its keep and last unchanged. FLUSH always applies in this case.
REQ-025 Invalid byte lanes of data_out SHALL be driven to 0.
REQ-026 While valid_out=1 and ready_out=0, data_out, keep_out and last_out SHALL hold stable.
REQ-027 A single-beat packet (last_in on the first beat) SHALL follow REQ-023.
REQ-028 A new header MAY be accepted in IDLE while the previous final beat is still waiting in the output register.

Reset
REQ-029 While rst_n=0:
- valid_out, data_out, keep_out, last_out, ready_in SHALL be 0;
- ready_insert SHALL be 0;
- the FSM SHALL be in IDLE and the header registers SHALL be cleared.
REQ-030 Reset asserted mid-packet SHALL abort the packet. After release, ready_insert SHALL be 1 on the first edge.

Verification
REQ-031 Header 0xAABBCCDD with N=2; payload 0x11223344, then 0x55667788 with keep 1111 and last; ready_out=1 -> outputs, each with the given keep and last:
- 0xCCDD1122, keep 1111, last 0;
- 0x33445566, keep 1111, last 0;
- 0x77880000, keep 1100, last 1.
REQ-032 Same header with N=2; payload 0x11223344, then 0x55000000 with keep 1000 and last -> outputs:
- 0xCCDD1122, keep 1111;
- 0x33445500, keep 1110, last 1.
REQ-033 byte_insert_cnt=0, header 0xAABBCCDD; payload 0x01020304 with keep 1100 and last -> outputs:
- 0xAABBCCDD, keep 1111;
- 0x01020000, keep 1100, last 1.
REQ-034 Backpressure: an 8-beat packet with N=2 and ready_out held 0 for 9 cycles, then 1 -> valid_out and data_out stay stable, ready_in stays 0 while the slot is full, and no bytes are lost or duplicated.
REQ-035 Assert rst_n=0 after 3 payload beats -> all outputs become 0 immediately; after release, a fresh header and packet produce correct output.

Source files
------------

// File: rtl/axi_stream_insert_header_pipe.sv
// Inserts an N-byte header in front of each AXI-Stream packet and repacks the
// payload MSB-first through a single registered output stage.
module axi_stream_insert_header_pipe #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam int CNT_WD = BYTE_CNT_WD + 2;
  localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(DATA_BYTE_WD);

  logic [1:0]              state_reg, state_next;
  logic [DATA_WD-1:0]      carry_reg, carry_next;
  logic [CNT_WD-1:0]       n_reg, n_next;
  logic [CNT_WD-1:0]       rem_reg, rem_next;
  logic                    init_reg;
  logic                    valid_out_reg, valid_out_next;
  logic [DATA_WD-1:0]      data_out_reg, data_out_next;
  logic [DATA_BYTE_WD-1:0] keep_out_reg, keep_out_next;
  logic                    last_out_reg, last_out_next;

  logic                    slot_free, pay_fire, hdr_fire;
  logic [DATA_WD-1:0]      pay_masked, shift_src, beat_data;
  logic [CNT_WD-1:0]       k_cnt, total_cnt;
  logic [DATA_BYTE_WD-1:0] keep_total, keep_rem;
  logic                    unused_keep_insert;

  assign slot_free          = !valid_out_reg || ready_out;
  assign ready_in           = (state_reg == STREAM) && slot_free;
  assign ready_insert       = init_reg && (state_reg == IDLE);
  assign pay_fire           = valid_in && ready_in;
  assign hdr_fire           = valid_insert && ready_insert;
  assign unused_keep_insert = ^keep_insert;

  // Only the last beat honours keep_in; dead lanes are zeroed so they never leak out.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_BYTE_WD; gi = gi + 1) begin : g_lane
      assign pay_masked[8*gi +: 8] = (last_in && !keep_in[gi]) ? 8'h00 : data_in[8*gi +: 8];
      assign keep_total[gi] = CNT_WD'(DATA_BYTE_WD - gi) <= total_cnt;
      assign keep_rem[gi]   = CNT_WD'(DATA_BYTE_WD - gi) <= rem_reg;
    end
  endgenerate

  always_comb begin
    k_cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) k_cnt = k_cnt + CNT_WD'(keep_in[i]);
  end

  assign total_cnt = n_reg + k_cnt;
  assign shift_src = (state_reg == FLUSH) ? '0 : pay_masked;
  // carry holds the header before the first beat, then the previous payload beat.
  assign beat_data = DATA_WD'({carry_reg, shift_src} >> {n_reg, 3'b000});

  always_comb begin
    state_next     = state_reg;
    carry_next     = carry_reg;
    n_next         = n_reg;
    rem_next       = rem_reg;
    valid_out_next = valid_out_reg && !ready_out;
    data_out_next  = data_out_reg;
    keep_out_next  = keep_out_reg;
    last_out_next  = last_out_reg;
    case (state_reg)
      IDLE: begin
        if (hdr_fire) begin
          carry_next = data_insert;
          n_next     = (byte_insert_cnt == '0) ? FULL_CNT : CNT_WD'(byte_insert_cnt);
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (pay_fire) begin
          carry_next     = pay_masked;
          valid_out_next = 1'b1;
          data_out_next  = beat_data;
          keep_out_next  = '1;
          last_out_next  = 1'b0;
          if (last_in) begin
            if (total_cnt <= FULL_CNT) begin
              keep_out_next = keep_total;
              last_out_next = 1'b1;
              state_next    = IDLE;
            end else begin
              rem_next   = total_cnt - FULL_CNT;
              state_next = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          valid_out_next = 1'b1;
          data_out_next  = beat_data;
          keep_out_next  = keep_rem;
          last_out_next  = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      carry_reg     <= '0;
      n_reg         <= '0;
      rem_reg       <= '0;
      init_reg      <= 1'b0;
      valid_out_reg <= 1'b0;
      data_out_reg  <= '0;
      keep_out_reg  <= '0;
      last_out_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      carry_reg     <= carry_next;
      n_reg         <= n_next;
      rem_reg       <= rem_next;
      init_reg      <= 1'b1;
      valid_out_reg <= valid_out_next;
      data_out_reg  <= data_out_next;
      keep_out_reg  <= keep_out_next;
      last_out_reg  <= last_out_next;
    end
  end

  assign valid_out = valid_out_reg;
  assign data_out  = data_out_reg;
  assign keep_out  = keep_out_reg;
  assign last_out  = last_out_reg;

endmodule

// File: tb/tb_axi_stream_insert_header_pipe.sv
// Scoreboard bench for axi_stream_insert_header_pipe: drivers queue hand-computed
// beats, an independent monitor checks every output handshake and stall.
module tb_axi_stream_insert_header_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;
  logic        valid_insert = 1'b0;
  logic [31:0] data_insert = '0;
  logic [3:0]  keep_insert = '0;
  logic [1:0]  byte_insert_cnt = '0;
  logic        ready_insert;

  always #5 clk = ~clk;

  axi_stream_insert_header_pipe #(.DATA_WD(32), .DATA_BYTE_WD(4), .BYTE_CNT_WD(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  typedef struct packed { logic [31:0] data; logic [3:0] keep; logic last; } beat_t;
  beat_t exp_q[$];
  int total = 0;
  int bad = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_keep = '0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic send_header(input logic [31:0] d, input logic [1:0] cnt);
    logic hs;
    int n;
    valid_insert = 1'b1; data_insert = d; byte_insert_cnt = cnt; keep_insert = 4'hF;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = ready_insert;
      @(posedge clk); #1; n++;
    end
    valid_insert = 1'b0;
    chk("header_handshake", {31'd0, hs}, 32'd1);
    $display("header sent data=%h cnt=%0d", d, cnt);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    logic hs;
    int n;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    hs = 1'b0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = ready_in;
      @(posedge clk); #1; n++;
    end
    valid_in = 1'b0; last_in = 1'b0;
    chk("payload_handshake", {31'd0, hs}, 32'd1);
    $display("payload sent data=%h keep=%b last=%b", d, k, l);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Monitor: output handshakes, hold-under-stall, and ready_in gating by a full slot.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && prev_stall) begin
        total++;
        if (!(valid_out && data_out == prev_data && keep_out == prev_keep && last_out == prev_last)) begin
          bad++;
          $display("FAIL hold_stable: got v=%b d=%h k=%b l=%b want v=1 d=%h k=%b l=%b",
                   valid_out, data_out, keep_out, last_out, prev_data, prev_keep, prev_last);
        end
      end
      if (rst_n && valid_out && !ready_out) begin
        total++;
        if (ready_in !== 1'b0) begin
          bad++;
          $display("FAIL ready_in_slot_full: got=%b want=0", ready_in);
        end
      end
      if (rst_n && valid_out && ready_out) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_beat: got d=%h k=%b l=%b want none", data_out, keep_out, last_out);
        end else begin
          e = exp_q.pop_front();
          if ({data_out, keep_out, last_out} !== e) begin
            bad++;
            $display("FAIL out_beat: got d=%h k=%b l=%b want d=%h k=%b l=%b",
                     data_out, keep_out, last_out, e.data, e.keep, e.last);
          end else begin
            $display("out beat d=%h k=%b l=%b", data_out, keep_out, last_out);
          end
        end
      end
      prev_stall = rst_n && valid_out && !ready_out;
      prev_data  = data_out;
      prev_keep  = keep_out;
      prev_last  = last_out;
    end
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", {31'd0, valid_out}, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_keep_out", {28'd0, keep_out}, 0);
    chk("rst_last_out", {31'd0, last_out}, 0);
    chk("rst_ready_in", {31'd0, ready_in}, 0);
    chk("rst_ready_insert", {31'd0, ready_insert}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_insert_after_release", {31'd0, ready_insert}, 1);

    // N=2, two full beats -> flush beat
    expect_beat(32'hCCDD1122, 4'b1111, 1'b0);
    expect_beat(32'h33445566, 4'b1111, 1'b0);
    expect_beat(32'h77880000, 4'b1100, 1'b1);
    send_header(32'hAABBCCDD, 2'd2);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
    drain();

    // N=2, short last beat fits
    expect_beat(32'hCCDD1122, 4'b1111, 1'b0);
    expect_beat(32'h33445500, 4'b1110, 1'b1);
    send_header(32'hAABBCCDD, 2'd2);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55000000, 4'b1000, 1'b1);
    drain();

    // N=4 (cnt=0): header beat, payload delayed unchanged
    expect_beat(32'hAABBCCDD, 4'b1111, 1'b0);
    expect_beat(32'h01020000, 4'b1100, 1'b1);
    send_header(32'hAABBCCDD, 2'd0);
    send_beat(32'h01020304, 4'b1100, 1'b1);
    drain();

    // N=1, single beat with N+K exactly a full beat
    expect_beat(32'h78A1B2C3, 4'b1111, 1'b1);
    send_header(32'h12345678, 2'd1);
    send_beat(32'hA1B2C3D4, 4'b1110, 1'b1);
    drain();

    // N=3, non-last keep ignored, last beat spills one byte
    expect_beat(32'hDEADBE01, 4'b1111, 1'b0);
    expect_beat(32'h02030405, 4'b1111, 1'b0);
    expect_beat(32'h06000000, 4'b1000, 1'b1);
    send_header(32'h00DEADBE, 2'd3);
    send_beat(32'h01020304, 4'b1000, 1'b0);
    send_beat(32'h05060708, 4'b1100, 1'b1);
    drain();

    // Backpressure: 8-beat packet, ready_out low for 9 cycles
    expect_beat(32'hCCDD0001, 4'b1111, 1'b0);
    expect_beat(32'h02030405, 4'b1111, 1'b0);
    expect_beat(32'h06070809, 4'b1111, 1'b0);
    expect_beat(32'h0A0B0C0D, 4'b1111, 1'b0);
    expect_beat(32'h0E0F1011, 4'b1111, 1'b0);
    expect_beat(32'h12131415, 4'b1111, 1'b0);
    expect_beat(32'h16171819, 4'b1111, 1'b0);
    expect_beat(32'h1A1B1C1D, 4'b1111, 1'b0);
    expect_beat(32'h1E1F0000, 4'b1100, 1'b1);
    ready_out = 1'b0;
    fork
      begin
        send_header(32'hAABBCCDD, 2'd2);
        for (int i = 0; i < 8; i++) begin
          logic [7:0] b0;
          b0 = 8'(4 * i);
          send_beat({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}, 4'b1111, i == 7);
        end
      end
      begin
        repeat (9) @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    drain();

    // New header accepted while the final beat still waits in the output register
    expect_beat(32'hABCD1100, 4'b1110, 1'b1);
    expect_beat(32'h12345678, 4'b1111, 1'b1);
    ready_out = 1'b0;
    send_header(32'h0000ABCD, 2'd2);
    send_beat(32'h11000000, 4'b1000, 1'b1);
    chk("held_valid_out", {31'd0, valid_out}, 1);
    chk("ready_insert_while_full", {31'd0, ready_insert}, 1);
    send_header(32'h00001234, 2'd2);
    repeat (2) @(posedge clk);
    #1;
    ready_out = 1'b1;
    send_beat(32'h56780000, 4'b1100, 1'b1);
    drain();

    // Reset after three payload beats aborts the packet
    expect_beat(32'hCCDD0001, 4'b1111, 1'b0);
    expect_beat(32'h02030405, 4'b1111, 1'b0);
    send_header(32'hAABBCCDD, 2'd2);
    send_beat(32'h00010203, 4'b1111, 1'b0);
    send_beat(32'h04050607, 4'b1111, 1'b0);
    send_beat(32'h08090A0B, 4'b1111, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", {31'd0, valid_out}, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_keep_out", {28'd0, keep_out}, 0);
    chk("midrst_last_out", {31'd0, last_out}, 0);
    chk("midrst_ready_in", {31'd0, ready_in}, 0);
    chk("midrst_ready_insert", {31'd0, ready_insert}, 0);
    chk("midrst_queue", exp_q.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_insert_after_midrst", {31'd0, ready_insert}, 1);

    // Fresh packet after reset, N=3
    expect_beat(32'h887766F0, 4'b1111, 1'b1);
    send_header(32'h99887766, 2'd3);
    send_beat(32'hF0E0D0C0, 4'b1000, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
